// File: rtl/stack_arbiter.sv
// stack_arbiter: shares a single-port hardware stack between two requesters.
// Round-robin grant, one PUSH or POP strobe per legal transaction, depth
// tracking with overflow/underflow rejection, and pop data returned after a
// fixed stack read latency.
module stack_arbiter #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 256,
  parameter int CNT_W   = 9,
  parameter int POP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic [1:0]       ack,
  output logic [WIDTH-1:0] rdata,
  output logic             err,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_value,
  input  logic [WIDTH-1:0] stk_data,
  output logic [CNT_W-1:0] depth,
  output logic             full,
  output logic             empty,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             op_q, op_d;
  logic             last_q, last_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] depth_q, depth_d;
  logic [1:0]       ack_q, ack_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             push_q, push_d;
  logic             pop_q, pop_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             win;
  logic             full_w;
  logic             empty_w;

  assign full_w  = (depth_q == CNT_W'(DEPTH));
  assign empty_w = (depth_q == '0);

  // Contention goes to the requester that was not served last.
  assign win = (req[0] && req[1]) ? ~last_q : req[1];

  // Next-state logic; strobes, ack and err are precomputed so they are
  // registered and appear for exactly the ISSUE / RESP cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    depth_d = depth_q;
    ack_d   = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    push_d  = 1'b0;
    pop_d   = 1'b0;
    value_d = value_q;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_d = win;
          op_d  = op[win];
          if ((op[win] && full_w) || (!op[win] && empty_w)) begin
            // Rejected: answer straight away without touching the stack.
            state_d    = RESP;
            ack_d[win] = 1'b1;
            err_d      = 1'b1;
          end else if (op[win]) begin
            state_d = ISSUE;
            push_d  = 1'b1;
            value_d = win ? wdata1 : wdata0;
            depth_d = depth_q + CNT_W'(1);
          end else begin
            state_d = ISSUE;
            pop_d   = 1'b1;
            depth_d = depth_q - CNT_W'(1);
          end
        end
      end
      ISSUE: begin
        if (op_q) begin
          state_d      = RESP;
          ack_d[gnt_q] = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 3'(POP_LAT);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d      = stk_data;
          state_d      = RESP;
          ack_d[gnt_q] = 1'b1;
        end
      end
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Transaction context, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q   <= 1'b0;
      op_q    <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      depth_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      value_q <= '0;
    end else begin
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      depth_q <= depth_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      value_q <= value_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign stk_push  = push_q;
  assign stk_pop   = pop_q;
  assign stk_value = value_q;
  assign depth     = depth_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: instance a (DEPTH=4, POP_LAT=1) and instance b
// (DEPTH=4, POP_LAT=3), each attached to a behavioural stack model.
module tb_stack_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance a signals
  logic [1:0] req_a, op_a, ack_a;
  logic [7:0] wd0_a, wd1_a, rdata_a, val_a, sdata_a;
  logic       err_a, push_a, pop_a, full_a, empty_a, busy_a;
  logic [2:0] depth_a;
  // instance b signals
  logic [1:0] req_b, op_b, ack_b;
  logic [7:0] wd0_b, wd1_b, rdata_b, val_b, sdata_b;
  logic       err_b, push_b, pop_b, full_b, empty_b, busy_b;
  logic [2:0] depth_b;

  stack_arbiter #(.WIDTH(8), .DEPTH(4), .CNT_W(3), .POP_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .op(op_a), .wdata0(wd0_a), .wdata1(wd1_a),
    .ack(ack_a), .rdata(rdata_a), .err(err_a), .stk_push(push_a), .stk_pop(pop_a),
    .stk_value(val_a), .stk_data(sdata_a), .depth(depth_a), .full(full_a),
    .empty(empty_a), .busy(busy_a));

  stack_arbiter #(.WIDTH(8), .DEPTH(4), .CNT_W(3), .POP_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .op(op_b), .wdata0(wd0_b), .wdata1(wd1_b),
    .ack(ack_b), .rdata(rdata_b), .err(err_b), .stk_push(push_b), .stk_pop(pop_b),
    .stk_value(val_b), .stk_data(sdata_b), .depth(depth_b), .full(full_b),
    .empty(empty_b), .busy(busy_b));

  // Stack models: read data is only valid in the one cycle POP_LAT edges after
  // the strobe edge; 0xEE is presented at every other time.
  logic [7:0] mem_a [4];
  logic [7:0] mem_b [4];
  int         sp_a, sp_b;
  logic       va;
  logic [7:0] da;
  logic [2:0] pv_b;
  logic [7:0] pipe_b [3];
  int         npush_a = 0, npop_a = 0, npush_b = 0, npop_b = 0;
  logic [7:0] lastval_a = 8'h00;

  assign sdata_a = va ? da : 8'hEE;
  assign sdata_b = pv_b[2] ? pipe_b[2] : 8'hEE;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_a <= 0; sp_b <= 0; va <= 1'b0; pv_b <= 3'b000;
    end else begin
      va <= pop_a;
      if (push_a && sp_a < 4) begin mem_a[sp_a] <= val_a; sp_a <= sp_a + 1; end
      if (pop_a && sp_a > 0) begin da <= mem_a[sp_a-1]; sp_a <= sp_a - 1; end
      pv_b <= {pv_b[1:0], pop_b};
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
      if (push_b && sp_b < 4) begin mem_b[sp_b] <= val_b; sp_b <= sp_b + 1; end
      if (pop_b && sp_b > 0) begin pipe_b[0] <= mem_b[sp_b-1]; sp_b <= sp_b - 1; end
    end
  end

  always @(posedge clk) begin
    if (push_a) begin npush_a <= npush_a + 1; lastval_a <= val_a; end
    if (pop_a)  npop_a  <= npop_a + 1;
    if (push_b) npush_b <= npush_b + 1;
    if (pop_b)  npop_b  <= npop_b + 1;
  end

  typedef struct {
    int         inst;
    logic [1:0] ack;
    logic       err;
    logic       chk_rd;
    logic [7:0] rd;
    int         cyc;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_fail = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void chk_resp(input int inst, input logic [1:0] a, input logic e,
                                   input logic [7:0] rd);
    exp_t x;
    n_vec++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_ack: inst=%0d ack=%b at cyc %0d, expected no ack", inst, a, cyc);
      return;
    end
    x = sbq.pop_front();
    if (x.inst != inst || a !== x.ack || e !== x.err || (x.chk_rd && rd !== x.rd) ||
        (x.cyc >= 0 && cyc != x.cyc)) begin
      n_fail++;
      $display("FAIL %s: inst=%0d ack=%b err=%b rdata=%h cyc=%0d, expected inst=%0d ack=%b err=%b rdata=%h cyc=%0d",
               x.nm, inst, a, e, rd, cyc, x.inst, x.ack, x.err, x.rd, x.cyc);
    end
  endfunction

  // Monitor: pops the scoreboard on every ack and checks strobe exclusivity.
  always @(negedge clk) begin
    if (ack_a != 2'b00) chk_resp(0, ack_a, err_a, rdata_a);
    if (ack_b != 2'b00) chk_resp(1, ack_b, err_b, rdata_b);
    if (ack_a == 2'b11 || ack_b == 2'b11) begin
      n_vec++; n_fail++;
      $display("FAIL double_ack: ack_a=%b ack_b=%b, expected one-hot", ack_a, ack_b);
    end
    if (push_a || pop_a) begin
      n_vec++;
      if (push_a && pop_a) begin n_fail++; $display("FAIL strobe_excl_a: push=1 pop=1, expected one"); end
    end
    if (push_b || pop_b) begin
      n_vec++;
      if (push_b && pop_b) begin n_fail++; $display("FAIL strobe_excl_b: push=1 pop=1, expected one"); end
    end
  end

  task automatic set_req(input int inst, input int r, input logic v, input logic o,
                         input logic [7:0] d);
    if (inst == 0) begin
      req_a[r] = v; op_a[r] = o;
      if (r == 0) wd0_a = d; else wd1_a = d;
    end else begin
      req_b[r] = v; op_b[r] = o;
      if (r == 0) wd0_b = d; else wd1_b = d;
    end
  endtask

  task automatic wait_ack(input int inst, input int r, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = (inst == 0) ? ack_a[r] : ack_b[r];
    end
    if (!got) begin
      n_vec++; n_fail++;
      $display("FAIL %s_timeout: no ack within 30 cycles, expected ack", nm);
    end
  endtask

  function automatic void expect_resp(input int inst, input int r, input logic e_err,
                                      input logic e_chk, input logic [7:0] e_rd,
                                      input int c, input string nm);
    exp_t x;
    x.inst = inst; x.ack = (r == 0) ? 2'b01 : 2'b10; x.err = e_err;
    x.chk_rd = e_chk; x.rd = e_rd; x.cyc = c; x.nm = nm;
    sbq.push_back(x);
  endfunction

  task automatic do_req(input int inst, input int r, input logic o, input logic [7:0] d,
                        input logic e_err, input logic e_chk, input logic [7:0] e_rd,
                        input int lat, input string nm);
    int p0, q0;
    @(negedge clk);
    set_req(inst, r, 1'b1, o, d);
    expect_resp(inst, r, e_err, e_chk, e_rd, cyc + lat, nm);
    p0 = (inst == 0) ? npush_a : npush_b;
    q0 = (inst == 0) ? npop_a : npop_b;
    wait_ack(inst, r, nm);
    set_req(inst, r, 1'b0, o, d);
    chk({nm, "_npush"}, ((inst == 0) ? npush_a : npush_b) - p0, (o && !e_err) ? 1 : 0);
    chk({nm, "_npop"},  ((inst == 0) ? npop_a : npop_b) - q0, (!o && !e_err) ? 1 : 0);
  endtask

  task automatic drv2(input int r, input logic o0, input logic [7:0] d0,
                      input logic o1, input logic [7:0] d1);
    @(negedge clk);
    set_req(0, r, 1'b1, o0, d0);
    wait_ack(0, r, "t3_first");
    set_req(0, r, 1'b1, o1, d1);
    wait_ack(0, r, "t3_second");
    set_req(0, r, 1'b0, o1, d1);
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_ack"}, ack_a, 2'b00);
    chk({t, "_err"}, err_a, 1'b0);
    chk({t, "_rdata"}, rdata_a, 8'h00);
    chk({t, "_stk_push"}, push_a, 1'b0);
    chk({t, "_stk_pop"}, pop_a, 1'b0);
    chk({t, "_stk_value"}, val_a, 8'h00);
    chk({t, "_depth"}, depth_a, 3'd0);
    chk({t, "_full"}, full_a, 1'b0);
    chk({t, "_empty"}, empty_a, 1'b1);
    chk({t, "_busy"}, busy_a, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_a = '0; op_a = '0; wd0_a = '0; wd1_a = '0;
    req_b = '0; op_b = '0; wd0_b = '0; wd1_b = '0;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst = 1'b0;

    // 1: single push from requester 0
    do_req(0, 0, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h00, 2, "t1_push_a5");
    chk("t1_stk_value", lastval_a, 8'hA5);
    chk("t1_depth", depth_a, 3'd1);
    chk("t1_empty", empty_a, 1'b0);

    // 2: LIFO order through requester 1, pop latency 3
    do_req(0, 1, 1'b1, 8'h11, 1'b0, 1'b1, 8'h00, 2, "t2_push_11");
    do_req(0, 1, 1'b1, 8'h22, 1'b0, 1'b1, 8'h00, 2, "t2_push_22");
    do_req(0, 1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 3, "t2_pop_22");
    do_req(0, 1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 3, "t2_pop_11");
    do_req(0, 1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 3, "t2_pop_a5");
    chk("t2_depth", depth_a, 3'd0);

    // 3: both requesters contend continuously; grants alternate 0,1,0,1
    expect_resp(0, 0, 1'b0, 1'b0, 8'h00, -1, "t3_g0_push31");
    expect_resp(0, 1, 1'b0, 1'b0, 8'h00, -1, "t3_g1_push41");
    expect_resp(0, 0, 1'b0, 1'b1, 8'h41, -1, "t3_g0_pop41");
    expect_resp(0, 1, 1'b0, 1'b1, 8'h31, -1, "t3_g1_pop31");
    fork
      drv2(0, 1'b1, 8'h31, 1'b0, 8'h00);
      drv2(1, 1'b1, 8'h41, 1'b0, 8'h00);
    join
    chk("t3_depth", depth_a, 3'd0);

    // 4: underflow, fill to capacity, overflow
    do_req(0, 0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h31, 1, "t4_pop_empty");
    chk("t4_depth_empty", depth_a, 3'd0);
    do_req(0, 0, 1'b1, 8'h51, 1'b0, 1'b1, 8'h31, 2, "t4_fill1");
    do_req(0, 0, 1'b1, 8'h52, 1'b0, 1'b1, 8'h31, 2, "t4_fill2");
    do_req(0, 0, 1'b1, 8'h53, 1'b0, 1'b1, 8'h31, 2, "t4_fill3");
    do_req(0, 0, 1'b1, 8'h54, 1'b0, 1'b1, 8'h31, 2, "t4_fill4");
    chk("t4_full", full_a, 1'b1);
    do_req(0, 0, 1'b1, 8'h55, 1'b1, 1'b1, 8'h31, 1, "t4_push_full");
    chk("t4_full_after", full_a, 1'b1);
    chk("t4_depth_full", depth_a, 3'd4);

    // 5: reset while a pop waits for stack data
    @(negedge clk);
    set_req(0, 0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy_wait", busy_a, 1'b1);
    rst = 1'b1;
    #1;
    chk_rst("t5_rst");
    set_req(0, 0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_req(0, 0, 1'b1, 8'h66, 1'b0, 1'b1, 8'h00, 2, "t5_push_66");
    chk("t5_depth", depth_a, 3'd1);

    // 6: POP_LAT=3 instance
    do_req(1, 0, 1'b1, 8'h77, 1'b0, 1'b1, 8'h00, 2, "t6_push_77");
    do_req(1, 0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 5, "t6_pop_77");
    do_req(1, 1, 1'b1, 8'h88, 1'b0, 1'b1, 8'h77, 2, "t6_push_88");
    do_req(1, 1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h88, 5, "t6_pop_88");
    chk("t6_depth", depth_b, 3'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
